// File: rtl/shift_chain.sv
// Driver for a daisy chain of 74HC595-style shift registers: master reset, shift,
// latch, output enable and shift+latch commands over a vld/rdy handshake.
module shift_chain #(
  parameter int unsigned DW     = 16,
  parameter int unsigned DIV    = 4,
  parameter int unsigned STCP_W = 4,
  parameter int unsigned MR_W   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_vld,
  input  logic [2:0]    i_cmd,
  input  logic          i_cmd_oen,
  input  logic          i_cmd_msb,
  input  logic [DW-1:0] i_din,
  output logic          o_rdy,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_sft_shcp,
  output logic          o_sft_ds,
  output logic          o_sft_stcp,
  output logic          o_sft_mr_n,
  output logic          o_sft_oe_n
);

  localparam int unsigned BW   = $clog2(DW + 1);
  localparam int unsigned PW   = $clog2(2 * DIV);
  localparam int unsigned WMAX = (MR_W > STCP_W) ? MR_W : STCP_W;
  localparam int unsigned WW   = $clog2(WMAX + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [PW-1:0] PH_RISE  = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_FALL  = PW'(2 * DIV - 1);
  localparam logic [WW-1:0] MR_LAST  = WW'(MR_W - 1);
  localparam logic [WW-1:0] ST_LAST  = WW'(STCP_W - 1);

  typedef enum logic [1:0] {StIdle, StMr, StShift, StLatch} state_e;

  state_e        r_state, w_state;
  logic [DW-1:0] r_sreg, w_sreg, w_sreg_sh;
  logic          r_msb, w_msb;
  logic          r_then_latch, w_then_latch;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic [PW-1:0] r_pcnt, w_pcnt;
  logic [WW-1:0] r_wcnt, w_wcnt;
  logic          r_shcp, w_shcp;
  logic          r_ds, w_ds;
  logic          r_stcp, w_stcp;
  logic          r_mr_n, w_mr_n;
  logic          r_oe_n, w_oe_n;
  logic          r_done, w_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_sreg       <= '0;
      r_msb        <= 1'b0;
      r_then_latch <= 1'b0;
      r_bcnt       <= '0;
      r_pcnt       <= '0;
      r_wcnt       <= '0;
      r_shcp       <= 1'b0;
      r_ds         <= 1'b0;
      r_stcp       <= 1'b0;
      r_mr_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_sreg       <= w_sreg;
      r_msb        <= w_msb;
      r_then_latch <= w_then_latch;
      r_bcnt       <= w_bcnt;
      r_pcnt       <= w_pcnt;
      r_wcnt       <= w_wcnt;
      r_shcp       <= w_shcp;
      r_ds         <= w_ds;
      r_stcp       <= w_stcp;
      r_mr_n       <= w_mr_n;
      r_oe_n       <= w_oe_n;
      r_done       <= w_done;
    end
  end

  // Next bit sits at the end of the register the chain reads from.
  assign w_sreg_sh = r_msb ? (r_sreg << 1) : (r_sreg >> 1);

  always_comb begin
    w_state      = r_state;
    w_sreg       = r_sreg;
    w_msb        = r_msb;
    w_then_latch = r_then_latch;
    w_bcnt       = r_bcnt;
    w_pcnt       = r_pcnt;
    w_wcnt       = r_wcnt;
    w_shcp       = r_shcp;
    w_ds         = r_ds;
    w_stcp       = r_stcp;
    w_mr_n       = r_mr_n;
    w_oe_n       = r_oe_n;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_vld) begin
          case (i_cmd)
            3'b000: begin
              w_state = StMr;
              w_mr_n  = 1'b0;
              w_wcnt  = '0;
            end
            3'b001, 3'b100: begin
              w_state      = StShift;
              w_sreg       = i_din;
              w_msb        = i_cmd_msb;
              w_then_latch = i_cmd[2];
              w_ds         = i_cmd_msb ? i_din[DW-1] : i_din[0];
              w_shcp       = 1'b0;
              w_pcnt       = '0;
              w_bcnt       = '0;
            end
            3'b010: begin
              w_state = StLatch;
              w_stcp  = 1'b1;
              w_wcnt  = '0;
            end
            3'b011: begin
              w_oe_n = i_cmd_oen;
              w_done = 1'b1;
            end
            default: w_done = 1'b1;
          endcase
        end
      end
      StMr: begin
        if (r_wcnt == MR_LAST) begin
          w_mr_n  = 1'b1;
          w_done  = 1'b1;
          w_wcnt  = '0;
          w_state = StIdle;
        end else begin
          w_wcnt = r_wcnt + 1'b1;
        end
      end
      StShift: begin
        if (r_pcnt == PH_RISE) begin
          w_shcp = 1'b1;
          w_pcnt = r_pcnt + 1'b1;
        end else if (r_pcnt == PH_FALL) begin
          // Data only moves on the falling shcp edge.
          w_shcp = 1'b0;
          w_pcnt = '0;
          if (r_bcnt == BIT_LAST) begin
            w_ds   = 1'b0;
            w_bcnt = '0;
            if (r_then_latch) begin
              w_state = StLatch;
              w_stcp  = 1'b1;
              w_wcnt  = '0;
            end else begin
              w_done  = 1'b1;
              w_state = StIdle;
            end
          end else begin
            w_bcnt = r_bcnt + 1'b1;
            w_sreg = w_sreg_sh;
            w_ds   = r_msb ? w_sreg_sh[DW-1] : w_sreg_sh[0];
          end
        end else begin
          w_pcnt = r_pcnt + 1'b1;
        end
      end
      StLatch: begin
        if (r_wcnt == ST_LAST) begin
          w_stcp  = 1'b0;
          w_done  = 1'b1;
          w_wcnt  = '0;
          w_state = StIdle;
        end else begin
          w_wcnt = r_wcnt + 1'b1;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  assign o_rdy      = (r_state == StIdle);
  assign o_busy     = ~o_rdy;
  assign o_done     = r_done;
  assign o_sft_shcp = r_shcp;
  assign o_sft_ds   = r_ds;
  assign o_sft_stcp = r_stcp;
  assign o_sft_mr_n = r_mr_n;
  assign o_sft_oe_n = r_oe_n;

endmodule
